// File: rtl/spi_axil_pkg.sv
// Shared constants and FSM encodings for the SPI IP's AXI4-Lite register slave.
package spi_axil_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB        = 2;

  localparam logic [3:0] REG_CTRL_OFS = 4'h0;
  localparam logic [3:0] REG_CFG_OFS  = 4'h4;
  localparam logic [3:0] REG_TXD_OFS  = 4'h8;
  localparam logic [3:0] REG_AUX_OFS  = 4'hC;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_HAVE_ADDR = 2'd1,
    WR_HAVE_DATA = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;
endpackage

// File: rtl/spi_axil_strb_reg.sv
// One 32-bit control register with byte enables, sync clear and a 1-cycle write pulse.
module spi_axil_strb_reg
  import spi_axil_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic [3:0]  strb_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o,
  output logic        pulse_o
);
  logic [31:0] q_q, q_d;
  logic        pulse_q;

  always_comb begin
    q_d = q_q;
    for (int k = 0; k < 4; k++)
      if (we_i && strb_i[k]) q_d[8*k +: 8] = d_i[8*k +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      pulse_q <= we_i;
    end
  end

  assign q_o     = q_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/spi_axil_slave_regs.sv
// AXI4-Lite slave register bank: AW/W in any order, byte strobes, SLVERR on unmapped words.
module spi_axil_slave_regs
  import spi_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  reg_out,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);
  localparam int IDX_W = ADDR_WIDTH - ADDR_LSB;

  wr_state_e         wr_q, wr_d;
  logic [IDX_W-1:0]  awidx_q, awidx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  rd_state_e         rd_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic [NUM_REGS-1:0][31:0] regs;
  logic              aw_hs, w_hs, ar_hs, commit, c_mapped, r_mapped;
  logic [IDX_W-1:0]  cidx, ridx;
  logic [31:0]       cdata, rd_word;
  logic [3:0]        cstrb;
  logic              unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = !S_AXI_ARESET && (wr_q == WR_IDLE || wr_q == WR_HAVE_DATA);
  assign S_AXI_WREADY  = !S_AXI_ARESET && (wr_q == WR_IDLE || wr_q == WR_HAVE_ADDR);
  assign S_AXI_ARREADY = !S_AXI_ARESET && (rd_q == RD_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit uses whichever half was latched earlier and takes the other from the bus.
  assign commit = (wr_q == WR_IDLE      && aw_hs && w_hs) ||
                  (wr_q == WR_HAVE_ADDR && w_hs) ||
                  (wr_q == WR_HAVE_DATA && aw_hs);
  assign cidx     = (wr_q == WR_HAVE_ADDR) ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign cdata    = (wr_q == WR_HAVE_DATA) ? wdata_q : S_AXI_WDATA;
  assign cstrb    = (wr_q == WR_HAVE_DATA) ? wstrb_q : S_AXI_WSTRB;
  assign c_mapped = {1'b0, cidx} < (IDX_W+1)'(NUM_REGS);

  always_comb begin
    wr_d     = wr_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    case (wr_q)
      WR_IDLE: begin
        if (aw_hs && !w_hs) begin
          awidx_d = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
          wr_d    = WR_HAVE_ADDR;
        end else if (w_hs && !aw_hs) begin
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
          wr_d    = WR_HAVE_DATA;
        end
      end
      WR_RESP: if (S_AXI_BREADY) begin
        bvalid_d = 1'b0;
        wr_d     = WR_IDLE;
      end
      default: ;
    endcase
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = c_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      wr_d     = WR_RESP;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_q     <= WR_IDLE;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= AXI_RESP_OKAY;
    end else begin
      wr_q     <= wr_d;
      awidx_q  <= awidx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    spi_axil_strb_reg u_reg (
      .clk_i   (S_AXI_ACLK),
      .clr_i   (S_AXI_ARESET),
      .we_i    (commit && c_mapped && (cidx == IDX_W'(i))),
      .strb_i  (cstrb),
      .d_i     (cdata),
      .q_o     (regs[i]),
      .pulse_o (reg_wr_pulse[i])
    );
  end

  // Read mux sees pre-commit register values, so a same-edge write is not visible.
  assign ridx     = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign r_mapped = {1'b0, ridx} < (IDX_W+1)'(NUM_REGS);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i)) rd_word = regs[i];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_q     <= RD_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
    end else if (rd_q == RD_IDLE) begin
      if (ar_hs) begin
        rd_q     <= RD_RESP;
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= r_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end else if (S_AXI_RREADY) begin
      rd_q     <= RD_IDLE;
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign reg_out      = regs;
endmodule

// File: tb/tb_spi_axil_slave_regs.sv
// Directed bench for spi_axil_slave_regs with a transaction-level model checked every cycle.
module tb_spi_axil_slave_regs;
  localparam int AW = 6;
  localparam int NR = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] pulse;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: pending AW/W halves, response slots and the register file.
  logic [31:0] mregs [NR];
  logic        m_have_aw, m_have_w, m_bvalid, m_rvalid;
  logic [AW-1:0] m_awaddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic [NR-1:0] m_pulse;
  bit          armed = 0;

  always @(negedge clk) begin
    logic m_awr, m_wr, m_arr, aw_h, w_h, ar_h;
    int idx;
    m_awr = !rst && !m_bvalid && !m_have_aw;
    m_wr  = !rst && !m_bvalid && !m_have_w;
    m_arr = !rst && !m_rvalid;
    if (armed) begin
      chk("m_reg_out", reg_out, {mregs[3], mregs[2], mregs[1], mregs[0]});
      chk("m_pulse", pulse, m_pulse);
      chk("m_awready", awready, m_awr);
      chk("m_wready", wready, m_wr);
      chk("m_arready", arready, m_arr);
      chk("m_bvalid", bvalid, m_bvalid);
      chk("m_bresp", bresp, m_bresp);
      chk("m_rvalid", rvalid, m_rvalid);
      chk("m_rdata", rdata, m_rdata);
      chk("m_rresp", rresp, m_rresp);
    end
    if (rst) begin
      for (int i = 0; i < NR; i++) mregs[i] = '0;
      m_have_aw = 0; m_have_w = 0; m_bvalid = 0; m_rvalid = 0;
      m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
      m_rdata = '0; m_bresp = 2'b00; m_rresp = 2'b00; m_pulse = '0;
      armed = 1;
    end else begin
      aw_h = awvalid && m_awr;
      w_h  = wvalid && m_wr;
      ar_h = arvalid && m_arr;
      m_pulse = '0;
      if (ar_h) begin
        idx = int'(araddr[AW-1:2]);
        m_rdata  = (idx < NR) ? mregs[idx] : 32'h0;
        m_rresp  = (idx < NR) ? 2'b00 : 2'b10;
        m_rvalid = 1;
      end else if (m_rvalid && rready) m_rvalid = 0;
      if (m_bvalid && bready) m_bvalid = 0;
      if (aw_h) begin m_have_aw = 1; m_awaddr = awaddr; end
      if (w_h)  begin m_have_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if (m_have_aw && m_have_w) begin
        idx = int'(m_awaddr[AW-1:2]);
        if (idx < NR) begin
          for (int k = 0; k < 4; k++)
            if (m_wstrb[k]) mregs[idx][8*k +: 8] = m_wdata[8*k +: 8];
          m_pulse[idx] = 1'b1;
          m_bresp = 2'b00;
        end else m_bresp = 2'b10;
        m_bvalid = 1; m_have_aw = 0; m_have_w = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL %s: handshake did not complete within 50 cycles", name);
  endtask

  // Issues AW/W (W leading AW by w_lead cycles); returns BRESP and cycles from last handshake to BVALID.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, output logic [1:0] resp, output int blat);
    bit aw_done = 0, w_done = 0, aw_h, w_h;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    wvalid = 1; awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      aw_h = awvalid && awready; w_h = wvalid && wready;
      tick(); n++;
      if (aw_h) begin aw_done = 1; awvalid = 0; end
      if (w_h)  begin w_done = 1; wvalid = 0; end
      if (!aw_done && !awvalid && n >= w_lead) awvalid = 1;
    end
    awvalid = 0; wvalid = 0; resp = 2'bxx; blat = 0;
    if (n >= 50) begin timeout("wr_addr_data"); return; end
    n = 0;
    while (n < 50) begin
      @(negedge clk); n++;
      if (bvalid) begin resp = bresp; blat = n; break; end
      tick();
    end
    if (n >= 50) begin timeout("wr_bvalid"); return; end
    if (bready) tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_h;
    int n = 0;
    araddr = a; arvalid = 1;
    while (arvalid && n < 50) begin
      @(negedge clk); ar_h = arready;
      tick(); n++;
      if (ar_h) arvalid = 0;
    end
    arvalid = 0; d = 'x; resp = 2'bxx;
    if (n >= 50) begin timeout("rd_addr"); return; end
    n = 0;
    while (n < 50) begin
      @(negedge clk); n++;
      if (rvalid) begin d = rdata; resp = rresp; break; end
      tick();
    end
    if (n >= 50) begin timeout("rd_rvalid"); return; end
    if (rready) tick();
  endtask

  initial begin
    logic [1:0] resp;
    logic [31:0] d;
    int blat;
    logic [127:0] snap;

    rst = 1; tick(); tick(); rst = 0;
    @(negedge clk);
    chk("reset_reg_out", reg_out, 128'h0);
    chk("reset_bvalid", bvalid, 1'b0);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("release_readies", {awready, wready, arready}, 3'b111);
    tick();

    // Simultaneous AW+W to each register, then read back.
    for (int i = 0; i < NR; i++) begin
      do_write(AW'(4*i), 32'(i + 1), 4'hF, 0, resp, blat);
      chk("t1_bresp", resp, 2'b00);
      chk("t1_bvalid_latency", blat, 1);
    end
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(4*i), d, resp);
      chk("t1_rdata", d, 32'(i + 1));
      chk("t1_rresp", resp, 2'b00);
    end
    chk("t1_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW.
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    @(negedge clk);
    chk("t2_wready_after_w", {awready, wready}, 2'b10);
    tick(); tick();
    awaddr = 6'h04; awvalid = 1;
    tick(); awvalid = 0;
    @(negedge clk);
    chk("t2_pulse", pulse, 4'b0010);
    chk("t2_bvalid", bvalid, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_pulse_gone", pulse, 4'b0000);
    tick();
    do_read(6'h04, d, resp);
    chk("t2_readback", d, 32'hA5A5A5A5);

    // Byte strobes.
    do_write(6'h00, 32'h11223344, 4'hF, 0, resp, blat);
    do_write(6'h00, 32'hAABBCCDD, 4'b0101, 1, resp, blat);
    chk("t3_reg0", reg_out[31:0], 32'h11BB33DD);

    // B back-pressure; a second AW waits until after the B handshake.
    bready = 0;
    do_write(6'h08, 32'h00000003, 4'hF, 0, resp, blat);
    tick();
    awaddr = 6'h0C; awvalid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_bvalid_held", {bvalid, bresp}, 3'b100);
      chk("t4_readies_low", {awready, wready}, 2'b00);
      tick();
    end
    bready = 1;
    @(negedge clk);
    chk("t4_aw_blocked_at_b_hs", awready, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_aw_ready_next", awready, 1'b1);
    tick(); awvalid = 0;
    wdata = 32'h0000_00CC; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    tick(); tick();
    chk("t4_reg3", reg_out[127:96], 32'h000000CC);

    // Same-edge read and write of register 2.
    araddr = 6'h08; arvalid = 1;
    awaddr = 6'h08; awvalid = 1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
    tick(); arvalid = 0; awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("t5_rdata_old", {rvalid, rdata}, {1'b1, 32'h3});
    tick(); tick();
    do_read(6'h08, d, resp);
    chk("t5_rdata_new", d, 32'h55);

    // Unmapped word, then reset while R is stalled.
    snap = reg_out;
    do_write(6'h20, 32'hDEADBEEF, 4'hF, 0, resp, blat);
    chk("t6_bresp_slverr", resp, 2'b10);
    chk("t6_no_change", reg_out, snap);
    do_read(6'h20, d, resp);
    chk("t6_rdata_zero", d, 32'h0);
    chk("t6_rresp_slverr", resp, 2'b10);
    rready = 0;
    araddr = 6'h00; arvalid = 1;
    tick(); arvalid = 0;
    @(negedge clk);
    chk("t6_rvalid_stalled", rvalid, 1'b1);
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("t6_rvalid_cleared", rvalid, 1'b0);
    chk("t6_regs_cleared", reg_out, 128'h0);
    rready = 1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
